// File: rtl/vending_ctrl.sv
// Session sequencer for the micro-vending machine: goods selection, coin credit,
// change computation, idle timeout and the one-hot state shown by the display blocks.
module vending_ctrl #(
  parameter logic [24:0] CNT_MAX   = 25'd49_999_999,
  parameter logic [3:0]  TIMEOUT_S = 4'd10,
  parameter logic [3:0]  TEMP_S    = 4'd3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       btn_confirm,
  input  logic       btn_pay,
  input  logic       btn_cancel,
  input  logic [2:0] sw_goods,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic [5:0] state,
  output logic [2:0] out_goods_high,
  output logic [2:0] out_goods_low,
  output logic [1:0] out_goods_num,
  output logic [7:0] paid,
  output logic [4:0] total,
  output logic [7:0] change,
  output logic       dispense
);

  typedef enum logic [5:0] {
    IDLE      = 6'h01,
    GOODS_ONE = 6'h02,
    GOODS_TWO = 6'h04,
    PAYMENT   = 6'h08,
    CHANGE    = 6'h10,
    TEMP      = 6'h20
  } state_t;

  state_t      state_q, state_n;
  logic [24:0] div_cnt;
  logic [3:0]  idle_cnt, idle_n;
  logic [3:0]  temp_cnt, temp_n;
  logic        refund_q, refund_n;
  logic [2:0]  high_n, low_n;
  logic [1:0]  num_n;
  logic [7:0]  paid_n, change_n, paid_new;
  logic [4:0]  total_n, coin_sum;
  logic        dispense_n, clr, tick, timeout, activity, abort;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {4'b0000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [4:0] price(input logic [2:0] code);
    return {2'b00, code} + 5'd1;
  endfunction

  assign tick     = (div_cnt == CNT_MAX);
  assign timeout  = (idle_cnt >= TIMEOUT_S);
  assign activity = btn_confirm | btn_pay | btn_cancel | coin_1 | coin_5 | coin_10;
  assign abort    = btn_cancel | timeout;
  assign coin_sum = (coin_1 ? 5'd1 : 5'd0) + (coin_5 ? 5'd5 : 5'd0) + (coin_10 ? 5'd10 : 5'd0);
  assign paid_new = sat_add8(paid, coin_sum);
  assign state    = state_q;

  always_comb begin
    state_n    = state_q;
    high_n     = out_goods_high;
    low_n      = out_goods_low;
    num_n      = out_goods_num;
    paid_n     = paid;
    total_n    = total;
    change_n   = change;
    refund_n   = refund_q;
    temp_n     = temp_cnt;
    idle_n     = idle_cnt;
    dispense_n = 1'b0;
    clr        = 1'b0;
    case (state_q)
      IDLE: if (btn_confirm) begin
        state_n = GOODS_ONE;
        clr     = 1'b1;
      end
      GOODS_ONE: if (abort) begin
        state_n = IDLE;
        clr     = 1'b1;
      end else if (btn_confirm) begin
        high_n  = sw_goods;
        num_n   = 2'd1;
        total_n = price(sw_goods);
        state_n = GOODS_TWO;
      end
      GOODS_TWO: if (abort) begin
        state_n = IDLE;
        clr     = 1'b1;
      end else if (btn_pay) begin
        state_n = PAYMENT;
      end else if (btn_confirm) begin
        low_n   = sw_goods;
        num_n   = 2'd2;
        total_n = total + price(sw_goods);
        state_n = PAYMENT;
      end
      PAYMENT: begin
        // An abort refunds everything credited, including coins landing this cycle.
        paid_n = paid_new;
        if (abort) begin
          change_n = paid_new;
          refund_n = 1'b1;
          state_n  = CHANGE;
        end else if (paid_new >= {3'b000, total}) begin
          change_n = paid_new - {3'b000, total};
          refund_n = 1'b0;
          state_n  = CHANGE;
        end
      end
      CHANGE: if (tick) begin
        state_n    = TEMP;
        temp_n     = 4'd0;
        dispense_n = ~refund_q;
      end
      TEMP: if (tick) begin
        if (temp_cnt == TEMP_S - 4'd1) state_n = IDLE;
        else                           temp_n  = temp_cnt + 4'd1;
      end
      default: begin
        state_n = IDLE;
        clr     = 1'b1;
      end
    endcase
    if (clr) begin
      high_n   = 3'd0;
      low_n    = 3'd0;
      num_n    = 2'd0;
      paid_n   = 8'd0;
      total_n  = 5'd0;
      change_n = 8'd0;
      refund_n = 1'b0;
    end
    // Idle counter saturates so a long stay in IDLE cannot wrap it.
    if (activity || (state_n != state_q)) idle_n = 4'd0;
    else if (tick && !timeout)            idle_n = idle_cnt + 4'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      div_cnt        <= '0;
      idle_cnt       <= '0;
      temp_cnt       <= '0;
      refund_q       <= 1'b0;
      out_goods_high <= '0;
      out_goods_low  <= '0;
      out_goods_num  <= '0;
      paid           <= '0;
      total          <= '0;
      change         <= '0;
      dispense       <= 1'b0;
    end else begin
      state_q        <= state_n;
      div_cnt        <= tick ? 25'd0 : div_cnt + 25'd1;
      idle_cnt       <= idle_n;
      temp_cnt       <= temp_n;
      refund_q       <= refund_n;
      out_goods_high <= high_n;
      out_goods_low  <= low_n;
      out_goods_num  <= num_n;
      paid           <= paid_n;
      total          <= total_n;
      change         <= change_n;
      dispense       <= dispense_n;
    end
  end

endmodule

// File: tb/tb_vending_ctrl.sv
// Scoreboard bench for vending_ctrl: a session-level reference model predicts every
// registered output; a monitor process pops and compares after each clock or reset.
module tb_vending_ctrl;

  localparam int CNT_MAX   = 4;
  localparam int TIMEOUT_S = 3;
  localparam int TEMP_S    = 2;

  localparam int P_IDLE = 0, P_G1 = 1, P_G2 = 2, P_PAY = 3, P_CHG = 4, P_TEMP = 5;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       btn_confirm = 1'b0, btn_pay = 1'b0, btn_cancel = 1'b0;
  logic [2:0] sw_goods = 3'd0;
  logic       coin_1 = 1'b0, coin_5 = 1'b0, coin_10 = 1'b0;
  logic [5:0] state;
  logic [2:0] out_goods_high, out_goods_low;
  logic [1:0] out_goods_num;
  logic [7:0] paid, change;
  logic [4:0] total;
  logic       dispense;

  vending_ctrl #(
    .CNT_MAX  (25'd4),
    .TIMEOUT_S(4'd3),
    .TEMP_S   (4'd2)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .btn_confirm   (btn_confirm),
    .btn_pay       (btn_pay),
    .btn_cancel    (btn_cancel),
    .sw_goods      (sw_goods),
    .coin_1        (coin_1),
    .coin_5        (coin_5),
    .coin_10       (coin_10),
    .state         (state),
    .out_goods_high(out_goods_high),
    .out_goods_low (out_goods_low),
    .out_goods_num (out_goods_num),
    .paid          (paid),
    .total         (total),
    .change        (change),
    .dispense      (dispense)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int st; int hi; int lo; int num; int paid; int total; int chg; int disp;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model: session phase, list of chosen codes, credit and change as plain ints.
  int m_ph, m_credit, m_chg, m_quiet, m_temp, m_cyc;
  bit m_refund, m_disp;
  int m_sel[$];

  function automatic int m_total();
    int s = 0;
    foreach (m_sel[i]) s += m_sel[i] + 1;
    return s;
  endfunction

  function automatic snap_t m_snap();
    snap_t s;
    s.st    = 1 << m_ph;
    s.hi    = (m_sel.size() > 0) ? m_sel[0] : 0;
    s.lo    = (m_sel.size() > 1) ? m_sel[1] : 0;
    s.num   = m_sel.size();
    s.paid  = m_credit;
    s.total = m_total();
    s.chg   = m_chg;
    s.disp  = int'(m_disp);
    return s;
  endfunction

  function automatic void session_clear();
    m_sel.delete();
    m_credit = 0;
    m_chg    = 0;
    m_refund = 1'b0;
  endfunction

  function automatic void model_reset();
    session_clear();
    m_ph = P_IDLE; m_quiet = 0; m_temp = 0; m_cyc = 0; m_disp = 1'b0;
  endfunction

  function automatic void model_step(input bit conf, input bit pay, input bit canc, input int g,
                                     input bit c1, input bit c5, input bit c10);
    bit tk, tmo, act;
    int old;
    tk  = (m_cyc % (CNT_MAX + 1)) == CNT_MAX;
    tmo = m_quiet >= TIMEOUT_S;
    act = conf | pay | canc | c1 | c5 | c10;
    old = m_ph;
    m_disp = 1'b0;
    case (m_ph)
      P_IDLE: if (conf) begin session_clear(); m_ph = P_G1; end
      P_G1: if (canc || tmo) begin session_clear(); m_ph = P_IDLE; end
            else if (conf) begin m_sel.push_back(g); m_ph = P_G2; end
      P_G2: if (canc || tmo) begin session_clear(); m_ph = P_IDLE; end
            else if (pay) m_ph = P_PAY;
            else if (conf) begin m_sel.push_back(g); m_ph = P_PAY; end
      P_PAY: begin
        m_credit = m_credit + int'(c1) + 5 * int'(c5) + 10 * int'(c10);
        if (m_credit > 255) m_credit = 255;
        if (canc || tmo) begin m_chg = m_credit; m_refund = 1'b1; m_ph = P_CHG; end
        else if (m_credit >= m_total()) begin
          m_chg = m_credit - m_total(); m_refund = 1'b0; m_ph = P_CHG;
        end
      end
      P_CHG: if (tk) begin m_ph = P_TEMP; m_temp = 0; m_disp = !m_refund; end
      P_TEMP: if (tk) begin
        m_temp++;
        if (m_temp >= TEMP_S) m_ph = P_IDLE;
      end
      default: ;
    endcase
    if (act || m_ph != old) m_quiet = 0;
    else if (tk && m_quiet < TIMEOUT_S) m_quiet++;
    m_cyc++;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are refreshed on every clock edge and on reset assertion.
  initial begin
    snap_t e;
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",  int'(state),          e.st);
        check("high",   int'(out_goods_high), e.hi);
        check("low",    int'(out_goods_low),  e.lo);
        check("num",    int'(out_goods_num),  e.num);
        check("paid",   int'(paid),           e.paid);
        check("total",  int'(total),          e.total);
        check("change", int'(change),         e.chg);
        check("dispense", int'(dispense),     e.disp);
      end
    end
  end

  task automatic cyc(input bit conf, input bit pay, input bit canc, input int g,
                     input bit c1, input bit c5, input bit c10);
    @(negedge sys_clk); #1;
    btn_confirm = conf; btn_pay = pay; btn_cancel = canc; sw_goods = 3'(g);
    coin_1 = c1; coin_5 = c5; coin_10 = c10;
    model_step(conf, pay, canc, g, c1, c5, c10);
    exp_q.push_back(m_snap());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_state(input int ph, input int bound, input string name);
    int k = 0;
    while (int'(state) != (1 << ph) && k < bound) begin
      idle(1);
      k++;
    end
    n_checks++;
    if (int'(state) != (1 << ph)) begin
      n_fail++;
      $display("FAIL %s: state %0h after %0d cycles, wanted %0h", name, state, bound, 1 << ph);
    end
  endtask

  task automatic apply_reset();
    @(negedge sys_clk); #1;
    btn_confirm = 0; btn_pay = 0; btn_cancel = 0; coin_1 = 0; coin_5 = 0; coin_10 = 0;
    model_reset();
    exp_q.push_back(m_snap());
    sys_rst_n = 1'b0;
    repeat (2) begin
      @(negedge sys_clk); #1;
      exp_q.push_back(m_snap());
    end
    @(negedge sys_clk); #1;
    sys_rst_n = 1'b1;
    model_step(0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(m_snap());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    // Idle behaviour and a coin in IDLE
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // Single item, code 3, paid exactly
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 3, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0, 0);
    wait_state(P_IDLE, 40, "single_item_done");
    // Two items 7 and 2, coins 10+5 together
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 7, 0, 0, 0);
    cyc(1, 0, 0, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    wait_state(P_IDLE, 40, "two_items_done");
    // Cancel in PAYMENT with a coin in the same cycle
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 4, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    wait_state(P_IDLE, 40, "cancel_done");
    // Timeout in GOODS_two
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    wait_state(P_IDLE, 40, "goods_timeout");
    // Timeout in PAYMENT with paid=2
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 4, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    wait_state(P_IDLE, 60, "payment_timeout");
    // Max total 16 against a stream of coin_10
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 7, 0, 0, 0);
    cyc(1, 0, 0, 7, 0, 0, 0);
    repeat (26) cyc(0, 0, 0, 0, 0, 0, 1);
    wait_state(P_IDLE, 40, "saturation_done");
    // Reset while in PAYMENT
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 5, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    apply_reset();
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      else if ($urandom_range(0, 49) == 0) idle(20);
      else cyc($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
               int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0);
    end
    idle(2);
    @(posedge sys_clk); #2;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
